// File: rtl/effect_mode_ctrl.sv
// Effect-mode controller: debounces the mode DIP switch and sequences a
// mute -> switch -> unmute handshake with the audio path on every accepted change.
module effect_mode_ctrl #(
    parameter int DB_CYCLES   = 500000,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic       sys_clk,
    input  logic       resetn,
    input  logic [3:0] ds_in,
    input  logic       mute_ack,
    output logic [3:0] mode,
    output logic       mode_valid,
    output logic       mute_req,
    output logic       busy,
    output logic       timeout_err
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int ACK_W = $clog2(ACK_TIMEOUT);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_MAX = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUTE,
        ST_SWITCH,
        ST_UNMUTE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cand;
    logic [3:0]         r_target;
    logic [3:0]         r_mode;
    logic [DB_W-1:0]    r_db_cnt;
    logic [ACK_W-1:0]   r_ack_cnt;
    logic               r_mode_valid;
    logic               r_mute_req;
    logic               r_timeout_err;
    logic               w_stable;

    // Any change of ds_in restarts the count, so short glitches never qualify.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_cand   <= 4'd0;
            r_db_cnt <= '0;
        end else if (ds_in != r_cand) begin
            r_cand   <= ds_in;
            r_db_cnt <= '0;
        end else if (r_db_cnt != DB_MAX) begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    assign w_stable = (r_db_cnt == DB_MAX) && (ds_in == r_cand);

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_target      <= 4'd0;
            r_mode        <= 4'd0;
            r_ack_cnt     <= '0;
            r_mode_valid  <= 1'b0;
            r_mute_req    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mode_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // target is frozen here; later switch moves wait for the next pass
                    if (w_stable && (r_cand != r_mode)) begin
                        r_target   <= r_cand;
                        r_ack_cnt  <= '0;
                        r_mute_req <= 1'b1;
                        r_state    <= ST_MUTE;
                    end
                end
                ST_MUTE: begin
                    // level-sensitive ack: an ack already high on entry is taken next edge
                    if (mute_ack) begin
                        r_ack_cnt <= '0;
                        r_state   <= ST_SWITCH;
                    end else if (r_ack_cnt == ACK_MAX) begin
                        r_ack_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_SWITCH;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                ST_SWITCH: begin
                    r_mode       <= r_target;
                    r_mode_valid <= 1'b1;
                    r_mute_req   <= 1'b0;
                    r_ack_cnt    <= '0;
                    r_state      <= ST_UNMUTE;
                end
                ST_UNMUTE: begin
                    if (!mute_ack) begin
                        r_ack_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else if (r_ack_cnt == ACK_MAX) begin
                        r_ack_cnt     <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                    end
                end
                default: begin
                    r_ack_cnt  <= '0;
                    r_mute_req <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mode        = r_mode;
    assign mode_valid  = r_mode_valid;
    assign mute_req    = r_mute_req;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_effect_mode_ctrl.sv
// Directed bench for effect_mode_ctrl with DB_CYCLES=4, ACK_TIMEOUT=8:
// a per-cycle vector table plus hand-written timeout, reset and handshake sequences.
module tb_effect_mode_ctrl;

    typedef struct {
        logic [3:0] ds;
        logic       ack;
        logic [3:0] mode;
        logic       mv;
        logic       mr;
        logic       busy;
        logic       te;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       resetn;
    logic [3:0] ds_in;
    logic       mute_ack;
    logic       ack_man;
    logic       ack_follow;
    logic       ack_q = 1'b0;
    logic [3:0] mode;
    logic       mode_valid;
    logic       mute_req;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad = 0;
    int mv_pulses = 0;
    int mv_base;
    vec_t vq[$];

    always #5 sys_clk = ~sys_clk;

    // Audio-path model: acknowledges mute_req one cycle late when enabled.
    always @(posedge sys_clk) ack_q <= mute_req;
    assign mute_ack = ack_follow ? ack_q : ack_man;

    always @(negedge sys_clk) if (resetn && mode_valid) mv_pulses <= mv_pulses + 1;

    effect_mode_ctrl #(
        .DB_CYCLES(4),
        .ACK_TIMEOUT(8)
    ) dut (
        .sys_clk(sys_clk),
        .resetn(resetn),
        .ds_in(ds_in),
        .mute_ack(mute_ack),
        .mode(mode),
        .mode_valid(mode_valid),
        .mute_req(mute_req),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic addv(input logic [3:0] ds, input logic ack, input logic [3:0] md,
                        input logic mv, input logic mr, input logic bz, input logic te);
        vec_t v;
        v.ds = ds; v.ack = ack; v.mode = md; v.mv = mv; v.mr = mr; v.busy = bz; v.te = te;
        vq.push_back(v);
    endtask

    task automatic wait_mv(input int maxc, input string nm);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick(1);
            if (mode_valid) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no mode_valid within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick(1);
            if (!busy) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: busy still high after %0d cycles", nm, maxc);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; ds_in = 4'd0; ack_man = 1'b0; ack_follow = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        // glitch rejection and ds equal to mode from reset
        for (int i = 0; i < 5; i++) addv(4'd0, 1'b0, 4'd0, 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) addv(4'd3, 1'b0, 4'd0, 0, 0, 0, 0);
            for (int i = 0; i < 3; i++) addv(4'd0, 1'b0, 4'd0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) addv(4'd0, 1'b0, 4'd0, 0, 0, 0, 0);
        // 0 -> 5 with ack one cycle behind mute_req
        for (int i = 0; i < 4; i++) addv(4'd5, 1'b0, 4'd0, 0, 0, 0, 0);
        addv(4'd5, 1'b0, 4'd0, 0, 1, 1, 0);
        addv(4'd5, 1'b0, 4'd0, 0, 1, 1, 0);
        addv(4'd5, 1'b1, 4'd0, 0, 1, 1, 0);
        addv(4'd5, 1'b1, 4'd5, 1, 0, 1, 0);
        addv(4'd5, 1'b1, 4'd5, 0, 0, 1, 0);
        addv(4'd5, 1'b0, 4'd5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) addv(4'd5, 1'b0, 4'd5, 0, 0, 0, 0);

        resetn = 1'b0; ds_in = 4'd0; ack_man = 1'b0; ack_follow = 1'b0;
        tick(1);
        check("reset_outputs", {mode, mode_valid, mute_req, busy, timeout_err}, 8'h00);
        tick(1);
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            ds_in = vq[i].ds;
            ack_man = vq[i].ack;
            tick(1);
            check($sformatf("vec%0d", i), {mode, mode_valid, mute_req, busy, timeout_err},
                  {vq[i].mode, vq[i].mv, vq[i].mr, vq[i].busy, vq[i].te});
        end

        // mute ack never arrives: MUTE times out, UNMUTE exits at once
        do_reset();
        ds_in = 4'd9;
        tick(12);
        check("to_before", {mute_req, busy, timeout_err}, 8'h6);
        tick(1);
        check("to_set", {mode, busy, timeout_err}, {4'd0, 1'b1, 1'b1});
        tick(1);
        check("to_switch", {mode, mode_valid, mute_req}, {4'd9, 1'b1, 1'b0});
        tick(1);
        check("to_idle", {busy, timeout_err, mode_valid}, 8'h2);

        // ds moves 5 -> 6 during MUTE: two back-to-back sequences
        mv_base = mv_pulses;
        ack_follow = 1'b1;
        ds_in = 4'd5;
        tick(5);
        check("chg_mute", {mute_req, busy}, 8'h3);
        ds_in = 4'd6;
        wait_mv(20, "chg_first");
        check("chg_mode5", mode, 8'd5);
        wait_idle(20, "chg_idle1");
        wait_mv(30, "chg_second");
        check("chg_mode6", mode, 8'd6);
        wait_idle(20, "chg_idle2");
        check("chg_pulses", 8'(mv_pulses - mv_base), 8'd2);
        check("te_sticky", timeout_err, 8'd1);

        // asynchronous reset while muting abandons the sequence
        ack_follow = 1'b0; ack_man = 1'b0;
        mv_base = mv_pulses;
        ds_in = 4'd2;
        tick(5);
        check("rst_pre", {mute_req, busy}, 8'h3);
        #2 resetn = 1'b0;
        #1;
        check("rst_async", {mode, mode_valid, mute_req, busy, timeout_err}, 8'h00);
        tick(2);
        check("rst_held", {mode, mute_req, busy}, 8'h00);
        resetn = 1'b1;
        tick(4);
        check("post_rst_wait", mute_req, 8'd0);
        tick(1);
        check("post_rst_rise", {mute_req, busy}, 8'h3);
        ack_follow = 1'b1;
        wait_mv(20, "post_rst_mv");
        check("post_rst_mode", mode, 8'd2);
        wait_idle(20, "post_rst_idle");
        check("post_rst_pulses", 8'(mv_pulses - mv_base), 8'd1);

        // ack already high at MUTE entry; then UNMUTE times out
        ack_follow = 1'b0; ack_man = 1'b1;
        ds_in = 4'd7;
        tick(5);
        check("pre_ack_mute", {mute_req, busy, timeout_err}, 8'h6);
        tick(1);
        check("pre_ack_switch", {mode, mode_valid, busy}, {4'd2, 1'b0, 1'b1});
        tick(1);
        check("pre_ack_mode", {mode, mode_valid, mute_req}, {4'd7, 1'b1, 1'b0});
        tick(7);
        check("un_to_before", {busy, timeout_err}, 8'h2);
        tick(1);
        check("un_to_set", {busy, timeout_err}, 8'h1);
        tick(6);
        check("un_to_quiet", {mode, busy, mode_valid}, {4'd7, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
